// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I instruction fields into machine words and streams them into imem.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [31:0]       wdata_reg;
  logic              finish_pend_reg;
  logic [31:0]       enc_word;
  logic              imm_bad;
  logic              restart;

  assign restart = start && (state_reg == IDLE || state_reg == DONE);

  always_comb begin
    enc_word = 32'h0;
    case (in_fmt)
      3'd0: enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
      3'd1: enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0010011};
      3'd2: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd3: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      3'd4: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd5: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      3'd6: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, 7'b1101111};
      default: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_reg;

  // An immediate fits N signed bits when every bit above N-1 copies the sign bit.
  always_comb begin
    imm_bad = 1'b0;
    case (in_fmt)
      3'd1, 3'd2, 3'd3, 3'd4: imm_bad = (in_imm[31:11] != {21{in_imm[11]}});
      3'd5: imm_bad = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      3'd6: imm_bad = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      3'd7: imm_bad = (in_imm[11:0] != 12'h0);
      default: imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (restart) begin
      err_reg <= 1'b0;
    end else if (state_reg == ACCEPT && in_valid && imm_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign imm_bad = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        // A rejected instruction still lets a simultaneous finish end the load.
        if (in_valid && !imm_bad) state_next = WRITE;
        else if (finish)          state_next = DONE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (addr_reg == LAST_ADDR || finish_pend_reg || finish) state_next = DONE;
        else                                                     state_next = ACCEPT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg        <= '0;
      count_reg       <= '0;
      wdata_reg       <= 32'h0;
      finish_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          finish_pend_reg <= 1'b0;
          if (start) begin
            addr_reg  <= '0;
            count_reg <= '0;
          end
        end
        ACCEPT: begin
          if (in_valid && !imm_bad) begin
            wdata_reg <= enc_word;
            if (finish) finish_pend_reg <= 1'b1;
          end
        end
        WRITE: begin
          // Address wraps naturally; the count stops at a full memory.
          addr_reg        <= addr_reg + 1'b1;
          finish_pend_reg <= 1'b0;
          if (count_reg != FULL_COUNT) count_reg <= count_reg + 1'b1;
        end
        default: begin
          finish_pend_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed table, corner sequences and
// randomized instructions checked against a shift-and-mask encoding model.
module tb_inst_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_fmt = 3'd0;
  logic [4:0]        in_rd = 5'd0;
  logic [4:0]        in_rs1 = 5'd0;
  logic [4:0]        in_rs2 = 5'd0;
  logic [2:0]        in_func3 = 3'd0;
  logic [6:0]        in_func7 = 7'd0;
  logic [31:0]       in_imm = 32'd0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  inst_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference state of the loader, kept at transaction level.
  int m_addr  = 0;
  int m_count = 0;
  bit m_done  = 1'b1;
  bit m_err   = 1'b0;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    logic [31:0] w;
    regs = (32'(rs1) << 15) | (32'(rd) << 7);
    case (fmt)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(f3) << 12) | 32'h33;
      3'd1: w = ((imm & 32'hFFF) << 20) | regs | (32'(f3) << 12) | 32'h13;
      3'd2: w = ((imm & 32'hFFF) << 20) | regs | (32'd2 << 12) | 32'h03;
      3'd3: w = ((imm & 32'hFFF) << 20) | regs | 32'h67;
      3'd4: w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
              | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
      3'd5: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      3'd6: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
              | (32'(rd) << 7) | 32'h6F;
      default: w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [2:0] fmt);
    logic [31:0] r;
    r = $urandom;
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      3'd1, 3'd2, 3'd3, 3'd4: r = {{20{r[11]}}, r[11:0]};
      3'd5: r = {{19{r[12]}}, r[12:1], 1'b0};
      3'd6: r = {{11{r[20]}}, r[20:1], 1'b0};
      3'd7: r = {r[31:12], 12'h0};
      default: r = r;
    endcase
`else
    r = r ^ {29'd0, fmt};
`endif
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = 0; m_count = 0; m_done = 1'b0; m_err = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_count", 32'(count), 32'd0);
    chk("start_addr", 32'(mem_addr), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
  endtask

  task automatic drive_fields(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_func7 = f7; in_imm = imm;
  endtask

  // One complete accepted instruction: handshake, one-cycle write, bookkeeping.
  task automatic do_instr(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic [31:0] exp_word, input bit fin, input string tag);
    int n;
    if (m_done) pulse_start();
    drive_fields(fmt, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    finish = fin;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s_handshake: in_ready never rose within 20 cycles", tag);
      in_valid = 1'b0;
      finish = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(m_addr));
    chk({tag, "_wdata"}, mem_wdata, exp_word);
    $display("txn %s fmt=%0d addr=%0d word=0x%08h", tag, fmt, m_addr, exp_word);
    @(negedge clk);
    m_addr = (m_addr + 1) % DEPTH;
    if (m_count < DEPTH) m_count++;
    m_done = fin || (m_count == DEPTH);
    chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_ready"}, 32'(in_ready), 32'(!m_done));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  logic [2:0]  r_fmt;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [31:0] r_imm;
  bit          r_fin;
  int          r_gap;
  int          r_n;

  initial begin
    vecs[0] = '{3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 32'h002081B3};
    vecs[1] = '{3'd1, 5'd5,  5'd0,  5'd9,  3'd0, 7'h55, 32'hFFFFFFFF, 32'hFFF00293};
    vecs[2] = '{3'd7, 5'd7,  5'd17, 5'd3,  3'd6, 7'h11, 32'h12345000, 32'h123453B7};
    vecs[3] = '{3'd4, 5'd31, 5'd1,  5'd2,  3'd7, 7'h7F, 32'h00000004, 32'h0020A223};
    vecs[4] = '{3'd5, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000008, 32'h00208463};
    vecs[5] = '{3'd6, 5'd1,  5'd4,  5'd5,  3'd3, 7'h01, 32'h00000010, 32'h010000EF};
    vecs[6] = '{3'd2, 5'd2,  5'd3,  5'd0,  3'd7, 7'h00, 32'h00000008, 32'h0081A103};
    vecs[7] = '{3'd3, 5'd0,  5'd1,  5'd0,  3'd5, 7'h00, 32'h00000000, 32'h00008067};
    vecs[8] = '{3'd0, 5'd5,  5'd6,  5'd7,  3'd0, 7'h20, 32'h00000000, 32'h407302B3};

    // Reset values while rst is held.
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Directed encodings; DEPTH=4 so these also wrap through full-memory restarts.
    for (int i = 0; i < 9; i++) begin
      do_instr(vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7,
               vecs[i].imm, vecs[i].word, 1'b0, $sformatf("vec%0d", i));
    end

    // Fill memory, then hold in_valid high in DONE: nothing may be accepted.
    while (!m_done) do_instr(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1,
                             ref_encode(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1), 1'b0, "fill");
    chk("full_count", 32'(count), 32'(DEPTH));
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_we", 32'(mem_we), 32'd0);
      chk("held_ready", 32'(in_ready), 32'd0);
      chk("held_count", 32'(count), 32'(DEPTH));
    end
    in_valid = 1'b0;
    pulse_start();

    // finish together with an accepted instruction.
    do_instr(3'd0, 5'd9, 5'd10, 5'd11, 3'd4, 7'd0, 32'd0,
             ref_encode(3'd0, 5'd9, 5'd10, 5'd11, 3'd4, 7'd0, 32'd0), 1'b1, "finval");
    chk("finval_done", 32'(done), 32'd1);

    // finish alone in ACCEPT.
    pulse_start();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("finonly_done", 32'(done), 32'd1);
    chk("finonly_we", 32'(mem_we), 32'd0);
    chk("finonly_count", 32'(count), 32'd0);
    m_done = 1'b1;

    // Out-of-range branch offset.
    pulse_start();
    drive_fields(3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
`ifdef IMM_RANGE_CHECK_EN
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("immerr_err", 32'(err), 32'd1);
    chk("immerr_we", 32'(mem_we), 32'd0);
    chk("immerr_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("immerr_count", 32'(count), 32'd0);
    m_err = 1'b1;
    do_instr(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000,
             ref_encode(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000), 1'b0, "aftererr");
`else
    do_instr(3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,
             ref_encode(3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7), 1'b0, "immtrunc");
`endif

    // Reset in the middle of a write.
    if (m_done) pulse_start();
    drive_fields(3'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_we", 32'(mem_we), 32'd0);
    chk("rstw_ready", 32'(in_ready), 32'd0);
    chk("rstw_addr", 32'(mem_addr), 32'd0);
    chk("rstw_wdata", mem_wdata, 32'd0);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_done = 1'b1;
    m_err = 1'b0;

    // Randomized instructions with idle gaps and occasional finish.
    for (int i = 0; i < 300; i++) begin
      r_fmt = 3'($urandom_range(0, 7));
      r_rd  = 5'($urandom);
      r_rs1 = 5'($urandom);
      r_rs2 = 5'($urandom);
      r_f3  = 3'($urandom);
      r_f7  = 7'($urandom);
      r_imm = gen_imm(r_fmt);
      r_fin = ($urandom_range(0, 9) == 0);
      r_gap = $urandom_range(0, 2);
      if (!m_done) begin
        for (r_n = 0; r_n < r_gap; r_n++) begin
          @(negedge clk);
          chk("gap_we", 32'(mem_we), 32'd0);
        end
      end
      do_instr(r_fmt, r_rd, r_rs1, r_rs2, r_f3, r_f7, r_imm,
               ref_encode(r_fmt, r_rd, r_rs1, r_rs2, r_f3, r_f7, r_imm), r_fin, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Inverse of the core's instruction decoder. Accepts decoded instruction fields (format class, register indices, func3/func7, immediate) over a valid/ready handshake. Packs them into 32-bit RV32I machine words and writes those words sequentially into instruction memory. Used by the test/boot infrastructure to load programs into imem before the core is released.

Parameters:
ADDR_W, 8, word-address width of instruction memory; capacity DEPTH = 2**ADDR_W words

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begin a new load at word address 0
finish  input  1  pulse; end of program, no more instructions
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept fields this cycle
in_fmt  input  3  0=R, 1=I-alu, 2=I-load, 3=jalr, 4=S, 5=B, 6=J, 7=U(lui)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_func3  input  3  func3 (used for R, I-alu, B)
in_func7  input  7  func7 (used for R only)
in_imm  input  32  sign-extended byte-offset/immediate value
mem_we  output  1  imem write strobe
mem_addr  output  ADDR_W  imem word address
mem_wdata  output  32  encoded instruction word
count  output  ADDR_W+1  words written since last start
done  output  1  load finished (finish seen or memory full)
err  output  1  immediate range error, sticky (optional feature)

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err=0, finish_pend=0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. start -> ACCEPT with mem_addr=0, count=0.
- ACCEPT: in_ready=1. On in_valid&in_ready, register the encoded word into mem_wdata and go to WRITE. Otherwise finish -> DONE.
- WRITE: mem_we=1 for exactly one cycle at the current mem_addr. Next cycle mem_addr+1 and count+1.
  - If mem_addr was DEPTH-1 or finish_pend: go to DONE and clear finish_pend. Otherwise go to ACCEPT.
- Throughput: one instruction per 2 cycles. Latency from handshake cycle to mem_we: 1 cycle.
- finish in the same cycle as an accepted instruction: the instruction is written, finish_pend is set, then DONE.
- finish during WRITE also sets finish_pend.
- DONE: done=1, in_ready=0, mem_we=0. in_valid is ignored and never accepted.
  - start -> ACCEPT with mem_addr=0, count=0, done=0, err=0.
- start outside IDLE/DONE: ignored.
- Full memory: count saturates at DEPTH and mem_addr wraps to 0. No further writes occur until start.
- Encoding (opcodes):
  - R 0110011: func7|rs2|rs1|func3|rd|op.
  - I-alu 0010011: imm[11:0]|rs1|func3|rd|op.
  - I-load 0000011: func3 forced to 010.
  - jalr 1100111: func3 forced to 000.
  - S 0100011: imm[11:5]|rs2|rs1|010|imm[4:0]|op.
  - B 1100011: imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|op. imm[0] is ignored.
  - J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - U 0110111: imm[31:12]|rd|op.
  - Fields not used by a format are ignored.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined:
  - An accepted in_imm out of signed range sets err (sticky until start). Ranges: I/load/jalr/S 12-bit; B 13-bit or odd; J 21-bit or odd.
  - U with imm[11:0]!=0 also sets err.
  - An erroring instruction is not written: go back to ACCEPT with no mem_we and no count change.
- Undefined: err tied 0, and the immediate is silently truncated to the encoded bits.

Test Plan:
- rst, start, R add rd=3 rs1=1 rs2=2 f3=0 f7=0 -> mem_we one cycle after handshake, mem_addr=0, mem_wdata=0x002081B3, count=1.
- I-alu rd=5 rs1=0 f3=0 imm=0xFFFFFFFF -> 0x FFF00293. U rd=7 imm=0x12345000 -> 0x123453B7.
- S rs1=1 rs2=2 imm=4 -> 0x0020A223. B rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463. J rd=1 imm=16 -> 0x010000EF. Words land at consecutive addresses.
- ADDR_W=2, four writes -> done=1 after the 4th write, count=4, in_ready=0. A fifth in_valid held high is never accepted. start -> addr 0, done=0.
- finish asserted with in_valid in the same cycle -> that word is written, then done=1. finish alone in ACCEPT -> done next cycle, no write.
- rst asserted in WRITE -> mem_we drops immediately, all outputs return to reset values. With IMM_RANGE_CHECK_EN, B imm=7 -> err=1, no write.
